// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: bundle between the requesting datapath blocks, the shared
// magnitude comparator and the cmp_arbiter sequencer.
//   req/a_in/b_in     requester side: level requests and packed operands
//   gnt/done          one-hot grant and one-cycle completion pulse
//   res_*/res_id/err  captured result, owning requester, sticky error
//   cmp_a/cmp_b       registered operands to the shared comparator
//   cmp_lt/eq/gt      comparator result back into the arbiter
// Modport slave is the arbiter's view; master is the surrounding logic.
interface cmp_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 2,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [W-1:0]      cmp_a;
    logic [W-1:0]      cmp_b;
    logic              cmp_lt;
    logic              cmp_eq;
    logic              cmp_gt;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              res_lt;
    logic              res_eq;
    logic              res_gt;
    logic [IDW-1:0]    res_id;
    logic              err;

    modport slave (
        input  req, a_in, b_in, cmp_lt, cmp_eq, cmp_gt,
        output cmp_a, cmp_b, gnt, done, res_lt, res_eq, res_gt, res_id, err
    );

    modport master (
        output req, a_in, b_in, cmp_lt, cmp_eq, cmp_gt,
        input  cmp_a, cmp_b, gnt, done, res_lt, res_eq, res_gt, res_id, err
    );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter that time-shares one external W-bit
// magnitude comparator among NREQ requesters.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cmp_arbiter_if.slave: requests/operands in, grant, comparator
//          operands, captured result with requester tag, done pulse, err
// Each compare takes two cycles: IDLE picks a winner and registers its
// operands onto the comparator; EVAL gives the comparator a full cycle to
// settle and captures lt/eq/gt on the exiting edge.
module cmp_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_arbiter_if.slave     bus
);

    typedef enum logic {IDLE, EVAL} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;     // highest-priority requester for next grant
    logic [IDW-1:0] cur;     // requester owning the in-flight compare

    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  win;
    logic            found;
    int              idx;

    // The requester finishing this cycle sits out one IDLE cycle; ptr has
    // already moved past it so others go first anyway.
    assign eligible = bus.req & ~bus.done;

    // First set bit at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cur        <= '0;
            bus.gnt    <= '0;
            bus.done   <= '0;
            bus.cmp_a  <= '0;
            bus.cmp_b  <= '0;
            bus.res_lt <= 1'b0;
            bus.res_eq <= 1'b0;
            bus.res_gt <= 1'b0;
            bus.res_id <= '0;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.gnt   <= NREQ'(1) << win;
                        bus.cmp_a <= bus.a_in[int'(win)*W +: W];
                        bus.cmp_b <= bus.b_in[int'(win)*W +: W];
                        cur       <= win;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    bus.res_lt <= bus.cmp_lt;
                    bus.res_eq <= bus.cmp_eq;
                    bus.res_gt <= bus.cmp_gt;
                    bus.res_id <= cur;
                    bus.done   <= bus.gnt;
                    bus.gnt    <= '0;
                    ptr        <= (int'(cur) == NREQ-1) ? '0 : cur + 1'b1;
                    // A healthy comparator asserts exactly one of lt/eq/gt.
                    bus.err    <= bus.err |
                                  ($countones({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt}) != 1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic fault;

    always #5 clk = ~clk;

    cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Shared comparator model; fault makes it assert lt and eq together.
    assign bus.cmp_lt = fault ? 1'b1 : (bus.cmp_a <  bus.cmp_b);
    assign bus.cmp_eq = fault ? 1'b1 : (bus.cmp_a == bus.cmp_b);
    assign bus.cmp_gt = fault ? 1'b0 : (bus.cmp_a >  bus.cmp_b);

    typedef struct {
        int         id;
        logic       lt, eq, gt;
        logic [1:0] a, b;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic lt, input logic eq, input logic gt,
                        input logic [1:0] a, input logic [1:0] b);
        item_t it;
        it.id = id; it.lt = lt; it.eq = eq; it.gt = gt; it.a = a; it.b = b;
        exp_q.push_back(it);
    endtask

    // Monitor: grant cycles are checked against the head of the queue, done
    // cycles pop it.
    always @(negedge clk) begin
        if (bus.gnt != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", {28'd0, bus.gnt}, 32'd0);
            end else begin
                chk("gnt",       {28'd0, bus.gnt}, 32'd1 << exp_q[0].id);
                chk("cmp_a",     {30'd0, bus.cmp_a}, {30'd0, exp_q[0].a});
                chk("cmp_b",     {30'd0, bus.cmp_b}, {30'd0, exp_q[0].b});
                chk("gnt_done",  {28'd0, bus.done}, 32'd0);
            end
        end
        if (bus.done != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {28'd0, bus.done}, 32'd0);
            end else begin
                item_t it;
                it = exp_q.pop_front();
                chk("done",   {28'd0, bus.done}, 32'd1 << it.id);
                chk("res",    {29'd0, bus.res_lt, bus.res_eq, bus.res_gt},
                              {29'd0, it.lt, it.eq, it.gt});
                chk("res_id", {30'd0, bus.res_id}, it.id);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        fault    = 1'b0;
        bus.req  = 4'b1111;
        bus.a_in = 8'b10_10_10_10;
        bus.b_in = 8'b10_10_10_10;

        // Reset with all requests held: everything quiet.
        repeat (3) @(negedge clk);
        chk("rst_gnt",   {28'd0, bus.gnt}, 32'd0);
        chk("rst_done",  {28'd0, bus.done}, 32'd0);
        chk("rst_cmp",   {28'd0, bus.cmp_a, bus.cmp_b}, 32'd0);
        chk("rst_res",   {26'd0, bus.res_lt, bus.res_eq, bus.res_gt, bus.res_id, bus.err}, 32'd0);

        // All four requesting, equal operands: order 0,1,2,3,0.
        push(0, 0, 1, 0, 2'd2, 2'd2);
        push(1, 0, 1, 0, 2'd2, 2'd2);
        push(2, 0, 1, 0, 2'd2, 2'd2);
        push(3, 0, 1, 0, 2'd2, 2'd2);
        push(0, 0, 1, 0, 2'd2, 2'd2);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);

        // Single request from 2: 3 vs 1 -> gt.
        bus.a_in = 8'b10_11_10_10;
        bus.b_in = 8'b10_01_10_10;
        push(2, 0, 0, 1, 2'd3, 2'd1);
        bus.req = 4'b0100;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Fresh ptr, requesters 1 and 3 alternate.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.a_in = 8'b10_00_00_00;
        bus.b_in = 8'b10_00_11_00;
        push(1, 1, 0, 0, 2'd0, 2'd3);
        push(3, 0, 1, 0, 2'd2, 2'd2);
        push(1, 1, 0, 0, 2'd0, 2'd3);
        push(3, 0, 1, 0, 2'd2, 2'd2);
        bus.req = 4'b1010;
        repeat (8) @(negedge clk);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);

        // Faulty comparator: lt and eq both high, result still captured.
        fault    = 1'b1;
        bus.a_in = 8'b00_00_00_01;
        bus.b_in = 8'b00_00_00_10;
        push(0, 1, 1, 0, 2'd1, 2'd2);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("err_set", {31'd0, bus.err}, 32'd1);
        fault = 1'b0;
        @(negedge clk);

        // Good compare afterwards: err stays sticky.
        bus.a_in = 8'b00_00_11_01;
        bus.b_in = 8'b00_00_00_10;
        push(1, 0, 0, 1, 2'd3, 2'd0);
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("err_sticky", {31'd0, bus.err}, 32'd1);

        // Reset clears err.
        rst_n = 1'b0;
        #1;
        chk("err_clr", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during EVAL for requester 3 aborts the compare.
        bus.a_in = 8'b01_00_00_00;
        bus.b_in = 8'b01_00_00_00;
        push(3, 0, 1, 0, 2'd1, 2'd1);
        bus.req = 4'b1000;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt",  {28'd0, bus.gnt}, 32'd0);
        chk("abort_done", {28'd0, bus.done}, 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        push(3, 0, 1, 0, 2'd1, 2'd1);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
